// File: rtl/cnn_layer_accel_prefetch_ring_buffer.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_prefetch_ring_buffer
//
// Prefetch row buffer for the CNN accelerator input path. Input rows are
// written once into a ring of NUM_SLOTS row slots. The read side streams an
// output frame that is nearest-neighbour upsampled by 2^up and zero-padded by
// pad pixels on every side. A slot is released only after the last output row
// that maps to its source row has been read, so every input row is fetched
// exactly once.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   cfg_load, cfg_num_cols,  frame configuration, latched in IDLE only
//   cfg_num_rows, cfg_pad,
//   cfg_up_log2
//   cfg_err                  one-cycle pulse when a cfg_load is rejected
//   wr_en, din, wr_ready     input pixel stream
//   rd_en, rd_ready          output pixel request
//   dout, dout_valid         output pixel, one cycle after an accepted rd_en
//   row_done, frame_done     flags aligned with the last pixel of a row/frame
//   slot_count               committed, not yet released slots
//   busy                     state is not IDLE
//
// Handshake: a transfer happens on a rising edge where en && ready. The ready
// signals depend only on state and counters, never on the matching enable,
// so a source may hold en high and a sink may inspect ready before driving en.
// ---------------------------------------------------------------------------
module cnn_layer_accel_prefetch_ring_buffer #(
    parameter int PIXEL_WIDTH = 16,
    parameter int MAX_COLS    = 512,
    parameter int MAX_ROWS    = 512,
    parameter int NUM_SLOTS   = 2,
    parameter int MAX_PAD     = 2,
    parameter int MAX_UP_LOG2 = 2,
    localparam int CW  = $clog2(MAX_COLS + 1),
    localparam int RW  = $clog2(MAX_ROWS + 1),
    localparam int PW  = $clog2(MAX_PAD + 1),
    localparam int UW  = $clog2(MAX_UP_LOG2 + 1),
    localparam int SCW = $clog2(NUM_SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [CW-1:0]          cfg_num_cols,
    input  logic [RW-1:0]          cfg_num_rows,
    input  logic [PW-1:0]          cfg_pad,
    input  logic [UW-1:0]          cfg_up_log2,
    output logic                   cfg_err,
    input  logic                   wr_en,
    input  logic [PIXEL_WIDTH-1:0] din,
    output logic                   wr_ready,
    input  logic                   rd_en,
    output logic                   rd_ready,
    output logic [PIXEL_WIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   row_done,
    output logic                   frame_done,
    output logic [SCW-1:0]         slot_count,
    output logic                   busy
);

    localparam int SW  = $clog2(NUM_SLOTS);
    localparam int CIW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    // Output counters must hold the largest padded, upsampled dimension.
    localparam int OCW = $clog2((MAX_COLS << MAX_UP_LOG2) + 2 * MAX_PAD + 1);
    localparam int ORW = $clog2((MAX_ROWS << MAX_UP_LOG2) + 2 * MAX_PAD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]          cols_q, cols_d;
    logic [RW-1:0]          rows_q, rows_d;
    logic [PW-1:0]          pad_q, pad_d;
    logic [UW-1:0]          up_q, up_d;
    logic [CW-1:0]          wr_col_q, wr_col_d;
    logic [SW-1:0]          wr_slot_q, wr_slot_d;
    logic [RW-1:0]          rows_written_q, rows_written_d;
    logic [ORW-1:0]         rd_r_q, rd_r_d;
    logic [OCW-1:0]         rd_c_q, rd_c_d;
    logic [SCW-1:0]         slot_count_q, slot_count_d;
    logic [PIXEL_WIDTH-1:0] dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   row_done_q, row_done_d;
    logic                   frame_done_q, frame_done_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [PIXEL_WIDTH-1:0] slot_mem [NUM_SLOTS][MAX_COLS];

    logic           cfg_ok;
    logic [OCW-1:0] img_c_end, out_cols, c_off, src_col_w;
    logic [ORW-1:0] img_r_end, out_rows, r_off, src_row_w, rep_mask;
    logic [RW-1:0]  src_row;
    logic [SW-1:0]  src_slot;
    logic [CIW-1:0] src_col;
    logic           row_pad, col_pad, is_pad;
    logic           last_col, last_row, last_rep;
    logic           wr_fire, rd_fire, commit, slot_release, frame_end;

    // Geometry decode of the current read position.
    always_comb begin : decode
        cfg_ok = (cfg_num_cols != '0) && (cfg_num_cols <= CW'(MAX_COLS)) &&
                 (cfg_num_rows != '0) && (cfg_num_rows <= RW'(MAX_ROWS)) &&
                 (cfg_pad <= PW'(MAX_PAD)) && (cfg_up_log2 <= UW'(MAX_UP_LOG2));

        img_c_end = OCW'(pad_q) + (OCW'(cols_q) << up_q);
        img_r_end = ORW'(pad_q) + (ORW'(rows_q) << up_q);
        out_cols  = img_c_end + OCW'(pad_q);
        out_rows  = img_r_end + ORW'(pad_q);

        row_pad = (rd_r_q < ORW'(pad_q)) || (rd_r_q >= img_r_end);
        col_pad = (rd_c_q < OCW'(pad_q)) || (rd_c_q >= img_c_end);
        is_pad  = row_pad || col_pad;

        // Offsets wrap on pad positions; they are only consumed when !is_pad.
        r_off     = rd_r_q - ORW'(pad_q);
        c_off     = rd_c_q - OCW'(pad_q);
        src_row_w = r_off >> up_q;
        src_col_w = c_off >> up_q;
        src_row   = RW'(src_row_w);
        src_col   = CIW'(src_col_w);
        // Rows are written in order, so the slot holding a source row is its
        // row index modulo NUM_SLOTS; this is the read-side slot pointer.
        src_slot  = src_row[SW-1:0];

        // Last of the 2^up repeats of a source row: low up bits of r_off all 1.
        rep_mask = (ORW'(1) << up_q) - ORW'(1);
        last_rep = !row_pad && ((r_off & rep_mask) == rep_mask);
        last_col = (rd_c_q == out_cols - OCW'(1));
        last_row = (rd_r_q == out_rows - ORW'(1));
    end

    // FSM output process.
    always_comb begin : fsm_out
        busy     = (state_q != ST_IDLE);
        wr_ready = (state_q == ST_RUN) && (slot_count_q < SCW'(NUM_SLOTS)) &&
                   (rows_written_q < rows_q);
        // Committed rows are exactly the rows already written, so a source row
        // is readable once its index is below the committed-row count.
        rd_ready = (state_q == ST_RUN) && (is_pad || (src_row < rows_written_q));
    end

    // FSM next-state process.
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_load && cfg_ok) state_d = ST_RUN;
            ST_RUN:  if (frame_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, config and output datapath.
    always_comb begin : datapath
        wr_fire      = wr_en && wr_ready;
        rd_fire      = rd_en && rd_ready;
        commit       = wr_fire && (wr_col_q == cols_q - CW'(1));
        slot_release = rd_fire && last_col && last_rep;
        frame_end    = rd_fire && last_col && last_row;

        cols_d         = cols_q;
        rows_d         = rows_q;
        pad_d          = pad_q;
        up_d           = up_q;
        wr_col_d       = wr_col_q;
        wr_slot_d      = wr_slot_q;
        rows_written_d = rows_written_q;
        rd_r_d         = rd_r_q;
        rd_c_d         = rd_c_q;
        slot_count_d   = slot_count_q;
        dout_d         = dout_q;
        dout_valid_d   = rd_fire;
        row_done_d     = rd_fire && last_col;
        frame_done_d   = frame_end;
        cfg_err_d      = (state_q == ST_IDLE) && cfg_load && !cfg_ok;

        if ((state_q == ST_IDLE) && cfg_load && cfg_ok) begin
            cols_d = cfg_num_cols;
            rows_d = cfg_num_rows;
            pad_d  = cfg_pad;
            up_d   = cfg_up_log2;
        end

        if (wr_fire) begin
            if (commit) begin
                wr_col_d       = '0;
                wr_slot_d      = wr_slot_q + SW'(1);
                rows_written_d = rows_written_q + RW'(1);
            end else begin
                wr_col_d = wr_col_q + CW'(1);
            end
        end

        if (rd_fire) begin
            dout_d = is_pad ? '0 : slot_mem[src_slot][src_col];
            if (last_col) begin
                rd_c_d = '0;
                rd_r_d = rd_r_q + ORW'(1);
            end else begin
                rd_c_d = rd_c_q + OCW'(1);
            end
        end

        case ({commit, slot_release})
            2'b10:   slot_count_d = slot_count_q + SCW'(1);
            2'b01:   slot_count_d = slot_count_q - SCW'(1);
            default: slot_count_d = slot_count_q;
        endcase

        // Outside RUN, and on the frame's final read, all ring state is
        // cleared so the next frame starts from slot 0.
        if ((state_q != ST_RUN) || frame_end) begin
            wr_col_d       = '0;
            wr_slot_d      = '0;
            rows_written_d = '0;
            rd_r_d         = '0;
            rd_c_d         = '0;
            slot_count_d   = '0;
        end
    end

    // State register process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cols_q         <= '0;
            rows_q         <= '0;
            pad_q          <= '0;
            up_q           <= '0;
            wr_col_q       <= '0;
            wr_slot_q      <= '0;
            rows_written_q <= '0;
            rd_r_q         <= '0;
            rd_c_q         <= '0;
            slot_count_q   <= '0;
            dout_q         <= '0;
            dout_valid_q   <= 1'b0;
            row_done_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cols_q         <= cols_d;
            rows_q         <= rows_d;
            pad_q          <= pad_d;
            up_q           <= up_d;
            wr_col_q       <= wr_col_d;
            wr_slot_q      <= wr_slot_d;
            rows_written_q <= rows_written_d;
            rd_r_q         <= rd_r_d;
            rd_c_q         <= rd_c_d;
            slot_count_q   <= slot_count_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            row_done_q     <= row_done_d;
            frame_done_q   <= frame_done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // Slot storage carries no reset: stale data is never read because a slot
    // is only readable after it has been fully rewritten and committed.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            slot_mem[wr_slot_q][wr_col_q[CIW-1:0]] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
    assign slot_count = slot_count_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_ring_buffer.sv
`timescale 1ns/1ps
module tb_cnn_layer_accel_prefetch_ring_buffer;
  localparam int PIXEL_WIDTH = 16;
  localparam int MAX_COLS    = 512;
  localparam int MAX_ROWS    = 512;
  localparam int NUM_SLOTS   = 2;
  localparam int MAX_PAD     = 2;
  localparam int MAX_UP_LOG2 = 2;
  localparam int CW  = $clog2(MAX_COLS + 1);
  localparam int RW  = $clog2(MAX_ROWS + 1);
  localparam int PW  = $clog2(MAX_PAD + 1);
  localparam int UW  = $clog2(MAX_UP_LOG2 + 1);
  localparam int SCW = $clog2(NUM_SLOTS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   cfg_load;
  logic [CW-1:0]          cfg_num_cols;
  logic [RW-1:0]          cfg_num_rows;
  logic [PW-1:0]          cfg_pad;
  logic [UW-1:0]          cfg_up_log2;
  logic                   cfg_err;
  logic                   wr_en;
  logic [PIXEL_WIDTH-1:0] din;
  logic                   wr_ready;
  logic                   rd_en;
  logic                   rd_ready;
  logic [PIXEL_WIDTH-1:0] dout;
  logic                   dout_valid;
  logic                   row_done;
  logic                   frame_done;
  logic [SCW-1:0]         slot_count;
  logic                   busy;

  cnn_layer_accel_prefetch_ring_buffer #(
    .PIXEL_WIDTH(PIXEL_WIDTH), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS),
    .NUM_SLOTS(NUM_SLOTS), .MAX_PAD(MAX_PAD), .MAX_UP_LOG2(MAX_UP_LOG2)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows),
    .cfg_pad(cfg_pad), .cfg_up_log2(cfg_up_log2), .cfg_err(cfg_err),
    .wr_en(wr_en), .din(din), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_ready(rd_ready),
    .dout(dout), .dout_valid(dout_valid), .row_done(row_done), .frame_done(frame_done),
    .slot_count(slot_count), .busy(busy)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int max_slot;
  logic [PIXEL_WIDTH-1:0] exp_q[$];

  typedef struct {
    int cols; int rows; int pad; int up;
    logic exp_err; logic exp_busy;
  } cfg_vec_t;

  typedef struct {
    int cols; int rows; int pad; int up;
    int oc; int n_out; int exp_off;
  } frame_vec_t;

  cfg_vec_t   cfg_tbl   [6];
  frame_vec_t frame_tbl [3];
  logic [PIXEL_WIDTH-1:0] exp_pix [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int c, input int r, input int p, input int u);
    cfg_num_cols = CW'(c);
    cfg_num_rows = RW'(r);
    cfg_pad      = PW'(p);
    cfg_up_log2  = UW'(u);
  endtask

  task automatic start_frame(input int c, input int r, input int p, input int u);
    drive_cfg(c, r, p, u);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cfg_err", 32'(cfg_err), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_row_done"}, 32'(row_done), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_slot_count"}, 32'(slot_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Holds wr_en and rd_en high, supplying pixels din_base, din_base+1, ...
  // and comparing every dout against exp_q. wr_en stays high past the last
  // row so that the DUT itself must refuse surplus writes.
  task automatic run_stream(input int oc, input int n_in, input int din_base,
                            input int out_start, input int total, input int budget);
    int acc_w = 0;
    int seen  = 0;
    int cyc   = 0;
    int n_out = exp_q.size();
    int pos;
    while (seen < n_out && cyc < budget) begin
      wr_en = 1'b1;
      din   = PIXEL_WIDTH'(din_base + acc_w);
      if (wr_ready) acc_w++;
      rd_en = 1'b1;
      tick();
      cyc++;
      if (int'(slot_count) > max_slot) max_slot = int'(slot_count);
      if (dout_valid) begin
        pos = out_start + seen;
        chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        chk("row_done", 32'(row_done), 32'(((pos + 1) % oc) == 0));
        chk("frame_done", 32'(frame_done), 32'((pos + 1) == total));
        seen++;
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (seen < n_out) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d outputs, expected %0d", seen, n_out);
      exp_q.delete();
    end
    chk("writes_accepted", 32'(acc_w), 32'(n_in));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int cyc;
    int rd_acc;
    int w_acc;

    cfg_tbl[0] = '{cols: 0,   rows: 3,   pad: 0, up: 0, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tbl[1] = '{cols: 4,   rows: 3,   pad: 0, up: 3, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tbl[2] = '{cols: 513, rows: 3,   pad: 0, up: 0, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tbl[3] = '{cols: 4,   rows: 0,   pad: 0, up: 0, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tbl[4] = '{cols: 4,   rows: 513, pad: 0, up: 0, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tbl[5] = '{cols: 4,   rows: 3,   pad: 3, up: 0, exp_err: 1'b1, exp_busy: 1'b0};

    frame_tbl[0] = '{cols: 4, rows: 3, pad: 0, up: 0, oc: 4, n_out: 12, exp_off: 0};
    frame_tbl[1] = '{cols: 2, rows: 2, pad: 1, up: 0, oc: 4, n_out: 16, exp_off: 12};
    frame_tbl[2] = '{cols: 2, rows: 2, pad: 1, up: 1, oc: 6, n_out: 36, exp_off: 28};

    exp_pix = '{
      // passthrough 4x3
      16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12,
      // pad 1 around 2x2
      16'd0, 16'd0, 16'd0, 16'd0,
      16'd0, 16'd1, 16'd2, 16'd0,
      16'd0, 16'd3, 16'd4, 16'd0,
      16'd0, 16'd0, 16'd0, 16'd0,
      // upsample x2, pad 1 around 2x2
      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
      16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0,
      16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0,
      16'd0, 16'd3, 16'd3, 16'd4, 16'd4, 16'd0,
      16'd0, 16'd3, 16'd3, 16'd4, 16'd4, 16'd0,
      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };

    rst      = 1'b1;
    cfg_load = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    drive_cfg(0, 0, 0, 0);
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Rejected configurations.
    for (int i = 0; i < 6; i++) begin
      drive_cfg(cfg_tbl[i].cols, cfg_tbl[i].rows, cfg_tbl[i].pad, cfg_tbl[i].up);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      chk($sformatf("cfg_err_%0d", i), 32'(cfg_err), 32'(cfg_tbl[i].exp_err));
      chk($sformatf("cfg_busy_%0d", i), 32'(busy), 32'(cfg_tbl[i].exp_busy));
      tick();
      chk($sformatf("cfg_err_pulse_%0d", i), 32'(cfg_err), 32'd0);
    end

    // Streamed frames.
    for (int f = 0; f < 3; f++) begin
      start_frame(frame_tbl[f].cols, frame_tbl[f].rows, frame_tbl[f].pad, frame_tbl[f].up);
      for (int j = 0; j < frame_tbl[f].n_out; j++) exp_q.push_back(exp_pix[frame_tbl[f].exp_off + j]);
      max_slot = 0;
      run_stream(frame_tbl[f].oc, frame_tbl[f].cols * frame_tbl[f].rows, 1, 0,
                 frame_tbl[f].n_out, 500);
      chk($sformatf("frame%0d_slot_max_ok", f), 32'(max_slot <= NUM_SLOTS), 32'd1);
      tick();
      chk($sformatf("frame%0d_idle_busy", f), 32'(busy), 32'd0);
      chk($sformatf("frame%0d_idle_slots", f), 32'(slot_count), 32'd0);
    end

    // Backpressure: fill both slots with no reads.
    start_frame(3, 4, 0, 0);
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 50) begin
      wr_en = 1'b1;
      din   = PIXEL_WIDTH'(k + 1);
      if (wr_ready) k++;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    chk("bp_writes", 32'(k), 32'd6);
    chk("bp_full_wr_ready", 32'(wr_ready), 32'd0);
    chk("bp_full_slots", 32'(slot_count), 32'd2);
    chk("bp_rd_ready", 32'(rd_ready), 32'd1);

    // cfg_load while running is ignored without an error pulse.
    drive_cfg(0, 0, 0, 0);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("run_cfg_err", 32'(cfg_err), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_still_full", 32'(wr_ready), 32'd0);

    // Read one full row; the release frees a slot for the next cycle.
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("bp_dout_%0d", i), 32'(dout), 32'(i + 1));
      chk($sformatf("bp_valid_%0d", i), 32'(dout_valid), 32'd1);
      chk($sformatf("bp_row_done_%0d", i), 32'(row_done), 32'(i == 2));
      chk($sformatf("bp_wr_ready_%0d", i), 32'(wr_ready), 32'(i == 2));
      chk($sformatf("bp_slots_%0d", i), 32'(slot_count), (i == 2) ? 32'd1 : 32'd2);
    end
    rd_en = 1'b0;

    // Write row 2 while reading row 1; last beat commits and releases together.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      din   = PIXEL_WIDTH'(7 + i);
      rd_en = 1'b1;
      chk($sformatf("sim_wr_ready_%0d", i), 32'(wr_ready), 32'd1);
      chk($sformatf("sim_rd_ready_%0d", i), 32'(rd_ready), 32'd1);
      tick();
      chk($sformatf("sim_dout_%0d", i), 32'(dout), 32'(4 + i));
      chk($sformatf("sim_slots_%0d", i), 32'(slot_count), 32'd1);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Drain rows 2 and 3.
    for (int j = 7; j <= 12; j++) exp_q.push_back(PIXEL_WIDTH'(j));
    max_slot = 0;
    run_stream(3, 3, 10, 6, 12, 200);
    chk("bp_slot_max_ok", 32'(max_slot <= NUM_SLOTS), 32'd1);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a frame after 5 reads.
    start_frame(4, 3, 0, 0);
    rd_acc = 0;
    w_acc  = 0;
    cyc    = 0;
    while (rd_acc < 5 && cyc < 100) begin
      wr_en = 1'b1;
      din   = PIXEL_WIDTH'(w_acc + 1);
      if (wr_ready) w_acc++;
      rd_en = 1'b1;
      if (rd_ready) rd_acc++;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mid_reads", 32'(rd_acc), 32'd5);
    chk("mid_dout", 32'(dout), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    tick();
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    // Fresh frame after reset.
    start_frame(4, 3, 0, 0);
    for (int j = 1; j <= 12; j++) exp_q.push_back(PIXEL_WIDTH'(j));
    max_slot = 0;
    run_stream(4, 12, 1, 0, 12, 200);
    tick();
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
